// File: rtl/fan_pkg.sv
// fan_pkg: shared types and constants for the fan-control sensor path.
//   sched_state_t : scheduler FSM states
//   temp_t        : 8-bit signed temperature
//   SENSOR1/2     : bus_sel encodings
//   TEMP_INVALID  : sentinel returned for a host read that timed out
//   sel_mask()    : one-hot stale-bit mask for a sensor select
package fan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  typedef logic signed [7:0] temp_t;

  localparam logic  SENSOR1      = 1'b0;
  localparam logic  SENSOR2      = 1'b1;
  localparam temp_t TEMP_INVALID = temp_t'(8'h80);

  function automatic logic [1:0] sel_mask(input logic sel);
    return (sel == SENSOR2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fan_sensor_scheduler_if.sv
// fan_sensor_scheduler_if: shared temperature-sensor read bus.
//   bus_req  : read request, held until ack or timeout
//   bus_sel  : addressed sensor, stable while bus_req = 1
//   bus_ack  : one-cycle response strobe
//   bus_data : signed reading, valid with bus_ack
// master = scheduler side, slave = sensor side.
interface fan_sensor_scheduler_if;
  import fan_pkg::*;

  logic  bus_req;
  logic  bus_sel;
  logic  bus_ack;
  temp_t bus_data;

  modport master (output bus_req, output bus_sel, input bus_ack, input bus_data);
  modport slave  (input bus_req, input bus_sel, output bus_ack, output bus_data);

endinterface

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: periodic round trigger.
//   clk, reset (sync, active-low), enable : counter runs only while enable = 1
//   tick : one-cycle pulse, registered, the cycle after the counter wraps
module sample_tick_gen #(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // Period counter: 0..PERIOD-1 while enabled, parked at 0 when disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/fan_sensor_scheduler.sv
// fan_sensor_scheduler: arbitrates the single sensor bus between a periodic
// poller (sensor 1 then sensor 2 every SAMPLE_PERIOD cycles) and a host read
// port, keeps the last good reading of each sensor and flags timeouts.
//   clk, reset (sync, active-low), enable (periodic polling)
//   bus        : sensor bus, master side
//   host_req/host_sel in; host_grant/host_data out (pulse + result)
//   sensor1_temp, sensor2_temp : last valid readings
//   stale      : bit n = sensor n+1 timed out on its latest access
//   round_done : one-cycle pulse per completed periodic round
module fan_sensor_scheduler
  import fan_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 100,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  fan_sensor_scheduler_if.master        bus,
  input  logic                          host_req,
  input  logic                          host_sel,
  output logic                          host_grant,
  output temp_t                         host_data,
  output temp_t                         sensor1_temp,
  output temp_t                         sensor2_temp,
  output logic [1:0]                    stale,
  output logic                          round_done
);

  localparam int unsigned    TCW     = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  sched_state_t   state_r, state_next_s;
  logic [TCW-1:0] tcnt_r;
  logic           cur_host_r, cur_sel_r, bus_req_r;
  logic           host_pend_r, host_sel_r, round_pend_r;
  logic           tick_s;
  logic           take_host_s, take_round_s, go_s2_s;
  logic           got_ack_s, timed_out_s, end_host_s, end_round_s, enter_done_s;

  sample_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick_s)
  );

  assign bus.bus_req  = bus_req_r;
  assign bus.bus_sel  = cur_sel_r;
  assign enter_done_s = got_ack_s | timed_out_s;

  // Next-state and event decode; host wins IDLE arbitration, rounds are atomic.
  always_comb begin
    state_next_s = state_r;
    take_host_s  = 1'b0;
    take_round_s = 1'b0;
    go_s2_s      = 1'b0;
    got_ack_s    = 1'b0;
    timed_out_s  = 1'b0;
    end_host_s   = 1'b0;
    end_round_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (host_pend_r) begin
          take_host_s  = 1'b1;
          state_next_s = ST_REQ;
        end else if (round_pend_r) begin
          take_round_s = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack is checked first so an ack on the final cycle counts as success.
        if (bus.bus_ack) begin
          got_ack_s    = 1'b1;
          state_next_s = ST_DONE;
        end else if (tcnt_r == TO_LAST) begin
          timed_out_s  = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DONE: begin
        if (cur_host_r) begin
          end_host_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else if (cur_sel_r == SENSOR1) begin
          go_s2_s      = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          end_round_s  = 1'b1;
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, transaction context, result registers, pending latches and pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      tcnt_r       <= '0;
      cur_host_r   <= 1'b0;
      cur_sel_r    <= SENSOR1;
      bus_req_r    <= 1'b0;
      host_pend_r  <= 1'b0;
      host_sel_r   <= SENSOR1;
      round_pend_r <= 1'b0;
      host_grant   <= 1'b0;
      host_data    <= '0;
      sensor1_temp <= '0;
      sensor2_temp <= '0;
      stale        <= 2'b00;
      round_done   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bus_req_r <= (state_next_s == ST_REQ);
      tcnt_r    <= (state_r == ST_REQ && state_next_s == ST_REQ) ? tcnt_r + TCW'(1) : '0;

      if (take_host_s) begin
        cur_host_r <= 1'b1;
        cur_sel_r  <= host_sel_r;
      end else if (take_round_s) begin
        cur_host_r <= 1'b0;
        cur_sel_r  <= SENSOR1;
      end else if (go_s2_s) begin
        cur_sel_r  <= SENSOR2;
      end

      if (got_ack_s) begin
        if (cur_sel_r == SENSOR1) begin
          sensor1_temp <= bus.bus_data;
        end else begin
          sensor2_temp <= bus.bus_data;
        end
        stale <= stale & ~sel_mask(cur_sel_r);
      end else if (timed_out_s) begin
        stale <= stale | sel_mask(cur_sel_r);
      end

      // Pulses are registered on DONE entry so they occupy the DONE cycle.
      host_grant <= enter_done_s && cur_host_r;
      round_done <= enter_done_s && !cur_host_r && (cur_sel_r == SENSOR2);
      if (enter_done_s && cur_host_r) begin
        host_data <= got_ack_s ? bus.bus_data : TEMP_INVALID;
      end

      // A request arriving in the DONE cycle of a host read re-arms the latch.
      if (host_req && (!host_pend_r || end_host_s)) begin
        host_pend_r <= 1'b1;
        host_sel_r  <= host_sel;
      end else if (end_host_s) begin
        host_pend_r <= 1'b0;
      end

      // Ticks arriving while a round is already pending are dropped.
      if (!enable) begin
        round_pend_r <= 1'b0;
      end else if (end_round_s) begin
        round_pend_r <= 1'b0;
      end else if (tick_s) begin
        round_pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fan_sensor_scheduler.sv
// Self-checking bench for fan_sensor_scheduler (SAMPLE_PERIOD = 100, TIMEOUT = 16).
module tb_fan_sensor_scheduler;
  import fan_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       host_req = 1'b0;
  logic       host_sel = 1'b0;
  logic       host_grant;
  logic [7:0] host_data;
  logic [7:0] s1_t, s2_t;
  logic [1:0] stale;
  logic       round_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rise = 0;
  int last_done = 0;

  fan_sensor_scheduler_if bus_if ();

  fan_sensor_scheduler #(.SAMPLE_PERIOD(100), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus_if),
    .host_req     (host_req),
    .host_sel     (host_sel),
    .host_grant   (host_grant),
    .host_data    (host_data),
    .sensor1_temp (s1_t),
    .sensor2_temp (s2_t),
    .stale        (stale),
    .round_done   (round_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       sel;
    int         delay;
    logic [7:0] data;
    bit         ack;
    logic [7:0] exp_host;
    logic [7:0] exp_s1;
    logic [7:0] exp_s2;
    logic [1:0] exp_stale;
  } hvec_t;

  hvec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge of the first REQ cycle; returns at the DONE-cycle negedge.
  task automatic serve(input logic exp_sel, input int delay, input logic [7:0] data,
                       input bit do_ack, input string tag);
    int n;
    chk({tag, " bus_sel"}, 32'(bus_if.bus_sel), 32'(exp_sel));
    if (do_ack) begin
      repeat (delay) @(negedge clk);
      bus_if.bus_ack  = 1'b1;
      bus_if.bus_data = data;
      @(negedge clk);
      bus_if.bus_ack  = 1'b0;
      bus_if.bus_data = 8'h00;
    end else begin
      n = 1;
      @(negedge clk);
      while (bus_if.bus_req && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk({tag, " req_cycles"}, 32'(n), 32'd16);
    end
    chk({tag, " bus_req_low_in_done"}, 32'(bus_if.bus_req), 32'd0);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int k;
    k = 0;
    while (!bus_if.bus_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " bus_req_seen"}, 32'(bus_if.bus_req), 32'd1);
    last_rise = cyc;
  endtask

  task automatic do_round(input int d1, input logic [7:0] v1, input bit a1,
                          input int d2, input logic [7:0] v2, input bit a2, input string tag);
    wait_req(250, tag);
    serve(SENSOR1, d1, v1, a1, {tag, " s1"});
    chk({tag, " no_round_done_after_s1"}, 32'(round_done), 32'd0);
    @(negedge clk);
    chk({tag, " s2_req_follows"}, 32'(bus_if.bus_req), 32'd1);
    serve(SENSOR2, d2, v2, a2, {tag, " s2"});
    chk({tag, " round_done_pulse"}, 32'(round_done), 32'd1);
    last_done = cyc;
    @(negedge clk);
    chk({tag, " round_done_one_cycle"}, 32'(round_done), 32'd0);
  endtask

  task automatic host_pulse(input logic sel);
    host_req = 1'b1;
    host_sel = sel;
    @(negedge clk);
    host_req = 1'b0;
    host_sel = 1'b0;
  endtask

  initial begin
    int prev_rise, prev_done, cnt;
    bus_if.bus_ack  = 1'b0;
    bus_if.bus_data = 8'h00;

    tbl[0] = '{1'b0, 0,  8'h64, 1'b1, 8'h64, 8'h64, 8'h00, 2'b00};
    tbl[1] = '{1'b1, 3,  8'hF9, 1'b1, 8'hF9, 8'h64, 8'hF9, 2'b00};
    tbl[2] = '{1'b0, 0,  8'h00, 1'b0, 8'h80, 8'h64, 8'hF9, 2'b01};
    tbl[3] = '{1'b0, 15, 8'h2A, 1'b1, 8'h2A, 8'h2A, 8'hF9, 2'b00};
    tbl[4] = '{1'b1, 0,  8'h00, 1'b0, 8'h80, 8'h2A, 8'hF9, 2'b10};
    tbl[5] = '{1'b1, 1,  8'h7F, 1'b1, 8'h7F, 8'h2A, 8'h7F, 2'b00};

    // Reset held 3 cycles with bus_ack toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.bus_ack = ~bus_if.bus_ack;
      chk("reset bus_req", 32'(bus_if.bus_req), 32'd0);
      chk("reset outputs", {host_grant, round_done, stale, host_data, s1_t, s2_t}, 32'd0);
    end
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Host reads from the table, polling disabled.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      host_pulse(tbl[i].sel);
      chk($sformatf("host%0d no_req_yet", i), 32'(bus_if.bus_req), 32'd0);
      @(negedge clk);
      chk($sformatf("host%0d req_latency", i), 32'(bus_if.bus_req), 32'd1);
      serve(tbl[i].sel, tbl[i].delay, tbl[i].data, tbl[i].ack, $sformatf("host%0d", i));
      chk($sformatf("host%0d grant", i), 32'(host_grant), 32'd1);
      chk($sformatf("host%0d data", i), 32'(host_data), 32'(tbl[i].exp_host));
      chk($sformatf("host%0d no_round_done", i), 32'(round_done), 32'd0);
      @(negedge clk);
      chk($sformatf("host%0d grant_one_cycle", i), 32'(host_grant), 32'd0);
      chk($sformatf("host%0d s1", i), 32'(s1_t), 32'(tbl[i].exp_s1));
      chk($sformatf("host%0d s2", i), 32'(s2_t), 32'(tbl[i].exp_s2));
      chk($sformatf("host%0d stale", i), 32'(stale), 32'(tbl[i].exp_stale));
    end

    // Second host_req while pending is ignored; a request in the DONE cycle is kept.
    @(negedge clk);
    host_pulse(1'b0);
    host_pulse(1'b1);
    chk("dup req_latency", 32'(bus_if.bus_req), 32'd1);
    serve(SENSOR1, 0, 8'h11, 1'b1, "dup");
    host_pulse(1'b1);
    chk("done_req idle_gap", 32'(bus_if.bus_req), 32'd0);
    @(negedge clk);
    chk("done_req latched", 32'(bus_if.bus_req), 32'd1);
    serve(SENSOR2, 0, 8'h22, 1'b1, "done_req");
    chk("done_req grant", 32'(host_grant), 32'd1);
    @(negedge clk);
    chk("dup s1", 32'(s1_t), 32'h11);
    chk("done_req s2", 32'(s2_t), 32'h22);
    repeat (3) @(negedge clk);
    chk("no_extra_host_txn", 32'(bus_if.bus_req), 32'd0);

    // Periodic rounds.
    enable = 1'b1;
    do_round(2, 8'h64, 1'b1, 2, 8'h32, 1'b1, "roundA");
    chk("roundA s1", 32'(s1_t), 32'h64);
    chk("roundA s2", 32'(s2_t), 32'h32);
    chk("roundA stale", 32'(stale), 32'd0);
    prev_rise = last_rise;
    prev_done = last_done;
    do_round(2, 8'h64, 1'b1, 2, 8'h32, 1'b1, "roundB");
    chk("period rise", 32'(last_rise - prev_rise), 32'd100);
    chk("period round_done", 32'(last_done - prev_done), 32'd100);

    // Host request in the same cycle as the period wrap.
    prev_rise = last_rise;
    while (cyc < prev_rise + 98) @(negedge clk);
    host_pulse(1'b1);
    wait_req(5, "prio");
    chk("prio rise_cycle", 32'(last_rise - prev_rise), 32'd100);
    serve(SENSOR2, 2, 8'h19, 1'b1, "prio host");
    chk("prio grant", 32'(host_grant), 32'd1);
    chk("prio host_data", 32'(host_data), 32'h19);
    chk("prio no_round_done", 32'(round_done), 32'd0);
    @(negedge clk);
    do_round(0, 8'h0A, 1'b1, 0, 8'h0B, 1'b1, "prio round");
    chk("min round length", 32'(last_done - last_rise), 32'd3);
    chk("prio s2", 32'(s2_t), 32'h0B);

    // Sensor 2 timeout, then recovery.
    do_round(0, 8'h1E, 1'b1, 0, 8'h00, 1'b0, "tmo");
    chk("tmo stale", 32'(stale), 32'b10);
    chk("tmo s2 kept", 32'(s2_t), 32'h0B);
    chk("tmo s1", 32'(s1_t), 32'h1E);
    do_round(1, 8'h1F, 1'b1, 1, 8'h28, 1'b1, "recover");
    chk("recover stale", 32'(stale), 32'd0);
    chk("recover s2", 32'(s2_t), 32'h28);

    // Reset during sensor 1 REQ.
    wait_req(250, "rst_mid");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_mid outputs", {host_grant, round_done, stale, host_data, s1_t, s2_t}, 32'd0);
    @(negedge clk);
    chk("rst_mid no_round_done", 32'(round_done), 32'd0);
    reset = 1'b1;
    do_round(1, 8'h05, 1'b1, 1, 8'h06, 1'b1, "restart");
    chk("restart s1", 32'(s1_t), 32'h05);
    chk("restart s2", 32'(s2_t), 32'h06);

    // enable dropped during the sensor 2 access.
    wait_req(250, "dis");
    serve(SENSOR1, 0, 8'h07, 1'b1, "dis s1");
    @(negedge clk);
    chk("dis s2_req", 32'(bus_if.bus_req), 32'd1);
    enable = 1'b0;
    serve(SENSOR2, 3, 8'h08, 1'b1, "dis s2");
    chk("dis round_done", 32'(round_done), 32'd1);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus_if.bus_req) cnt++;
    end
    chk("dis no_more_req", 32'(cnt), 32'd0);
    chk("dis s2", 32'(s2_t), 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_sensor_scheduler.md
# fan_sensor_scheduler

Shared-bus sensor scheduler for the fan-control subsystem. Owns the single temperature-sensor read bus and shares it between two requesters: a periodic poller, and an on-demand host read port. The periodic poller samples sensor 1 then sensor 2 once every `SAMPLE_PERIOD` cycles. Holds the last valid reading of each sensor and drives the `sensor1_temp` and `sensor2_temp` inputs of `FanController`. Flags sensors that stop answering.

## Interface
- `SAMPLE_PERIOD`, default 100: cycles between periodic round starts; legal range ≥ 4.
- `TIMEOUT`, default 16: maximum cycles `bus_req` stays high waiting for `bus_ack`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `enable` in 1: enables periodic polling.
- `bus_req` out 1: read request on the shared sensor bus.
- `bus_sel` out 1: addressed sensor (0 = sensor 1, 1 = sensor 2); stable while `bus_req` = 1.
- `bus_ack` in 1: sensor response strobe, one cycle.
- `bus_data` in 8, signed: sensor reading, valid with `bus_ack`.
- `host_req` in 1: on-demand read request; one-cycle pulse, latched internally.
- `host_sel` in 1: sensor for the host read; sampled together with `host_req`.
- `host_grant` out 1: one-cycle pulse when a host read finishes.
- `host_data` out 8, signed: host read result, valid with `host_grant`.
- `sensor1_temp`, `sensor2_temp` out 8, signed: last valid reading of each sensor.
- `stale` out 2: bit n set = sensor n+1 timed out on its most recent access.
- `round_done` out 1: one-cycle pulse when a periodic round completes.

## Operation
- **States:** IDLE, REQ, DONE.
- **Period counter:** counts 0..`SAMPLE_PERIOD`-1 while `enable` = 1. On wrap it sets `round_pend`. While `enable` = 0 the counter is held at 0 and `round_pend` is cleared.
- **Host latch:** `host_req` sets `host_pend` and stores `host_sel`. A second `host_req` while `host_pend` = 1 is ignored.
- **IDLE arbitration:**
  - `host_pend` is served first and starts a host transaction.
  - Otherwise `round_pend` starts the round's sensor 1 transaction.
  - A round is atomic: sensor 2 follows sensor 1 with no host service in between.
- **REQ:** `bus_req` = 1 and the timeout counter increments.
  - **On `bus_ack`:** capture `bus_data` into the addressed sensor register, clear that sensor's `stale` bit, go to DONE.
  - **At `TIMEOUT` cycles with no ack:** keep the old register value, set that sensor's `stale` bit, go to DONE.
- **DONE (1 cycle):** `bus_req` = 0.
  - **Host transaction:** pulse `host_grant` and clear `host_pend`. `host_data` is the captured value, or −128 (0x80 sentinel) on timeout.
  - **Round, sensor 1 finished:** return to REQ with `bus_sel` = 1.
  - **Round, sensor 2 finished:** pulse `round_done`, clear `round_pend`.
  - Otherwise go to IDLE.
- **Host reads:** a successful host read also updates the stored sensor register.
- **`enable` falling mid-round:** the in-flight round finishes; no new round starts.
- **Period wrap while `round_pend` = 1 (overrun):** the tick is dropped, not queued.
- **`bus_ack` outside REQ:** ignored.

## Timing
- **Reset values:**
  - All outputs 0, `stale` = 2'b00.
  - `host_pend`, `round_pend` and the counters are 0; FSM in IDLE.
- **Reset mid-transaction:** `bus_req` drops at that same edge and no pulses are emitted.
- **Start latency:** `bus_req` rises the cycle after IDLE sees a pending request. `host_req` to `bus_req` is 2 cycles when the bus is idle.
- **Ack latency:** `bus_ack` sampled at edge t updates the sensor register and enters DONE at t. `bus_req` is low from t onward; the `host_grant`/`round_done` pulse occurs in cycle t+1.
- **Timeout:** `bus_req` is high for exactly `TIMEOUT` cycles, then DONE.
- **Ack on the last timeout cycle:** treated as success.
- **Simultaneous events:**
  - `host_req` and period wrap in the same cycle: host is served first, then the round.
  - New `host_req` in the DONE cycle of a host read: latched as a new request.
- **Minimum round length:** 4 cycles, given immediate acks.

## Structure
- **Package `fan_pkg`:** state enum, `SENSOR1`/`SENSOR2` select encodings, `TEMP_INVALID` = −128, 8-bit signed temperature typedef; shared with `FanController`.
- **Sub-module `sample_tick_gen`:** period counter with `enable`, producing a one-cycle wrap pulse.
- **FSM, arbitration, timeout and result registers:** stay in the top level.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `bus_ack` toggling → all outputs 0, `bus_req` never asserted.
- **Periodic round:** `SAMPLE_PERIOD` = 100, ack after 2 cycles, data 100 then 50 → `sensor1_temp` = 100, `sensor2_temp` = 50, `round_done` one pulse per 100 cycles, `stale` = 0.
- **Host priority:** `host_req` with `host_sel` = 1 in the same cycle as the period wrap, data 25 → host transaction first, `host_grant` with `host_data` = 25, then a full round.
- **Timeout:** `TIMEOUT` = 16, sensor 2 never acks → `bus_req` high exactly 16 cycles, `stale` = 2'b10, `sensor2_temp` keeps its old value. A later good ack clears `stale[1]`.
- **Reset mid-REQ:** assert reset during sensor 1 REQ → `bus_req` low at that edge, no `round_done`, clean restart after release.
- **Disable:** `enable` dropped during the sensor 2 access → round completes with `round_done` pulse, no further `bus_req` for 300 cycles.
